// File: rtl/bin2bcd_arb.sv
// Round-robin arbiter sharing one combinational binary-to-BCD converter among R requesters.
// Optional conversion counter output conv_count is compiled in with `define BIN2BCD_ARB_CNT_EN.

module bin2bcd #(
   parameter int N = 8,
   // digit count of 2^N-1; 1233/4096 approximates log10(2)
   localparam int D = ((N * 1233) >> 12) + 1
) (
   input  logic [N-1:0]   bin,
   output logic [4*D-1:0] bcd
);

   logic [4*D-1:0] acc;

   // double-dabble: add 3 to any digit >= 5 before each left shift
   always_comb begin
      acc = '0;
      for (int i = N - 1; i >= 0; i--) begin
         for (int d = 0; d < D; d++) begin
            if (acc[4*d +: 4] >= 4'd5) begin
               acc[4*d +: 4] = acc[4*d +: 4] + 4'd3;
            end
         end
         acc = {acc[4*D-2:0], bin[i]};
      end
      bcd = acc;
   end

endmodule

module bin2bcd_arb #(
   parameter int N = 8,
   parameter int R = 4,
   localparam int D = ((N * 1233) >> 12) + 1,
   localparam int IW = $clog2(R)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [R-1:0]    req_valid,
   input  logic [R*N-1:0]  req_data,
   output logic [R-1:0]    req_ready,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [4*D-1:0]  out_bcd,
   output logic [IW-1:0]   out_id
`ifdef BIN2BCD_ARB_CNT_EN
   ,
   output logic [15:0]     conv_count
`endif
);

   typedef enum logic [1:0] {IDLE, CONV, OUT} state_t;

   state_t         state, state_next;
   logic [IW-1:0]  ptr;
   logic [IW-1:0]  winner;
   logic           found;
   int             scan_idx;
   logic           grant;
   logic           out_hs;
   logic [N-1:0]   data_reg;
   logic [IW-1:0]  id_reg;
   logic [4*D-1:0] conv_bcd;

   bin2bcd #(.N(N)) u_conv (
      .bin (data_reg),
      .bcd (conv_bcd)
   );

   // first valid requester at or after ptr, wrapping modulo R
   always_comb begin
      winner   = '0;
      found    = 1'b0;
      scan_idx = 0;
      for (int k = 0; k < R; k++) begin
         scan_idx = (int'(ptr) + k) % R;
         if (!found && req_valid[scan_idx]) begin
            winner = IW'(scan_idx);
            found  = 1'b1;
         end
      end
   end

   always_comb begin
      state_next = state;
      req_ready  = '0;
      out_valid  = 1'b0;
      grant      = 1'b0;
      out_hs     = 1'b0;
      case (state)
         IDLE: begin
            if (found && !rst) begin
               grant             = 1'b1;
               req_ready[winner] = 1'b1;
               state_next        = CONV;
            end
         end
         CONV: state_next = OUT;
         OUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               out_hs     = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr      <= '0;
         data_reg <= '0;
         id_reg   <= '0;
         out_bcd  <= '0;
         out_id   <= '0;
      end else begin
         if (grant) begin
            data_reg <= req_data[winner*N +: N];
            id_reg   <= winner;
            ptr      <= (winner == IW'(R - 1)) ? '0 : winner + 1'b1;
         end
         if (state == CONV) begin
            out_bcd <= conv_bcd;
            out_id  <= id_reg;
         end
      end
   end

`ifdef BIN2BCD_ARB_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         conv_count <= '0;
      end else if (out_hs) begin
         conv_count <= conv_count + 16'd1;
      end
   end
`endif

endmodule
